// File: rtl/counter8b_sweep_ctrl.sv
// Sequencer for the 8-bit up/down counter: sweeps it between programmed limits a
// programmed number of times with a dwell at each end, closing the loop on the readback.
module counter8b_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int SWP_W = 4,
    parameter int DWL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic [SWP_W-1:0] sweeps,
    input  logic [DWL_W-1:0] dwell,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SWP_W-1:0] sweep_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SEEK   = 3'd2,
        S_UP     = 3'd3,
        S_DWL_HI = 3'd4,
        S_DOWN   = 3'd5,
        S_DWL_LO = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t             state_r, next_s;
    logic [WIDTH-1:0]   lo_r, hi_r;
    logic [SWP_W-1:0]   sweeps_r, sweep_idx_r, idx_next_s;
    logic [DWL_W-1:0]   dwell_r, dwell_cnt_r;
    logic               busy_r, done_r, err_r;
    logic               load_s, bad_cfg_s, rb_fault_s, rb_err_s, idx_inc_s, dwell_end_s;

    assign idx_next_s  = sweep_idx_r + {{(SWP_W-1){1'b0}}, 1'b1};
    assign dwell_end_s = (dwell_cnt_r == dwell_r);
    assign rb_fault_s  = (cnt_value > hi_r) || (cnt_value < lo_r);

    // Next-state decode and combinational counter controls
    always_comb begin
        next_s    = state_r;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_dir   = 1'b1;
        load_s    = 1'b0;
        bad_cfg_s = 1'b0;
        rb_err_s  = 1'b0;
        idx_inc_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && (lo_lim < hi_lim) && (sweeps != {SWP_W{1'b0}})) begin
                    load_s = 1'b1;
                    next_s = S_CLEAR;
                end else begin
                    bad_cfg_s = start;
                end
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                next_s  = S_SEEK;
            end
            S_SEEK: begin
                if (cnt_value == lo_r) begin
                    next_s = S_UP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_UP: begin
                if (rb_fault_s) begin
                    rb_err_s = 1'b1;
                    next_s   = S_IDLE;
                end else if (cnt_value == hi_r) begin
                    next_s = S_DWL_HI;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DWL_HI: begin
                if (dwell_end_s) begin
                    next_s = S_DOWN;
                end else begin
                    next_s = S_DWL_HI;
                end
            end
            S_DOWN: begin
                cnt_dir = 1'b0;
                if (rb_fault_s) begin
                    rb_err_s = 1'b1;
                    next_s   = S_IDLE;
                end else if (cnt_value == lo_r) begin
                    next_s = S_DWL_LO;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DWL_LO: begin
                cnt_dir = 1'b0;
                if (dwell_end_s) begin
                    idx_inc_s = 1'b1;
                    next_s    = (idx_next_s == sweeps_r) ? S_DONE : S_UP;
                end else begin
                    next_s = S_DWL_LO;
                end
            end
            S_DONE: begin
                next_s = S_IDLE;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
        // Abort overrides everything: counter frozen, silent return to idle
        if (abort && (state_r != S_IDLE)) begin
            next_s    = S_IDLE;
            cnt_en    = 1'b0;
            cnt_clr   = 1'b0;
            rb_err_s  = 1'b0;
            idx_inc_s = 1'b0;
        end else begin
            next_s = next_s;
        end
    end

    // State, latched configuration, dwell timer and registered status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            lo_r        <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            sweeps_r    <= {SWP_W{1'b0}};
            dwell_r     <= {DWL_W{1'b0}};
            dwell_cnt_r <= {DWL_W{1'b0}};
            sweep_idx_r <= {SWP_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= next_s;
            if (load_s) begin
                lo_r        <= lo_lim;
                hi_r        <= hi_lim;
                sweeps_r    <= sweeps;
                dwell_r     <= dwell;
                sweep_idx_r <= {SWP_W{1'b0}};
            end else if (idx_inc_s) begin
                sweep_idx_r <= idx_next_s;
            end
            // Timer restarts whenever a dwell state is entered
            if (((state_r == S_DWL_HI) || (state_r == S_DWL_LO)) && (next_s == state_r)) begin
                dwell_cnt_r <= dwell_cnt_r + {{(DWL_W-1){1'b0}}, 1'b1};
            end else begin
                dwell_cnt_r <= {DWL_W{1'b0}};
            end
            busy_r <= (next_s != S_IDLE);
            done_r <= (next_s == S_DONE);
            err_r  <= bad_cfg_s | rb_err_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign sweep_idx = sweep_idx_r;

endmodule

// File: tb/tb_counter8b_sweep_ctrl.sv
// Directed bench for counter8b_sweep_ctrl with a behavioural model of the 8-bit counter.
module tb_counter8b_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort;
    logic [7:0] lo_lim, hi_lim;
    logic [3:0] sweeps, dwell;
    logic [7:0] cnt_value;
    logic       cnt_clr, cnt_en, cnt_dir, busy, done, err;
    logic [3:0] sweep_idx;

    logic [7:0] cnt_r = 8'd0;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int en_cyc, clr_cyc, done_cyc, err_cyc, busy_cyc, down_cyc, hold3_cyc;

    counter8b_sweep_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .sweeps(sweeps), .dwell(dwell),
        .cnt_value(cnt_value), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .busy(busy), .done(done), .err(err), .sweep_idx(sweep_idx)
    );

    always #5 clk = ~clk;

    assign cnt_value = force_en ? force_val : cnt_r;

    // Counter being sequenced
    always @(posedge clk) begin
        if (cnt_clr)     cnt_r <= 8'd0;
        else if (cnt_en) cnt_r <= cnt_dir ? cnt_r + 8'd1 : cnt_r - 8'd1;
    end

    // Per-cycle activity tallies, sampled mid-cycle after stimulus settles
    always @(negedge clk) begin
        #1;
        if (cnt_en)  en_cyc++;
        if (cnt_clr) clr_cyc++;
        if (done)    done_cyc++;
        if (err)     err_cyc++;
        if (busy)    busy_cyc++;
        if (busy && !cnt_dir)           down_cyc++;
        if (busy && cnt_value == 8'd3)  hold3_cyc++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_tallies();
        en_cyc = 0; clr_cyc = 0; done_cyc = 0; err_cyc = 0;
        busy_cyc = 0; down_cyc = 0; hold3_cyc = 0;
    endtask

    task automatic pulse_start(input logic [7:0] lo, input logic [7:0] hi,
                               input logic [3:0] sw, input logic [3:0] dw);
        @(negedge clk);
        clear_tallies();
        lo_lim = lo; hi_lim = hi; sweeps = sw; dwell = dw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lo_lim = 8'hAA; hi_lim = 8'h00; sweeps = 4'd0; dwell = 4'hF;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq({tag, "_timeout"}, 1, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cnt(input string tag, input logic [7:0] v, input logic dir);
        int n;
        n = 0;
        while (!(busy && cnt_value == v && cnt_dir == dir) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 400) check_eq({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        lo_lim = 8'd0; hi_lim = 8'd0; sweeps = 4'd0; dwell = 4'd0;
        clear_tallies();
        #12;
        check_eq("rst_clr",   cnt_clr, 0);
        check_eq("rst_en",    cnt_en, 0);
        check_eq("rst_dir",   cnt_dir, 1);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_err",   err, 0);
        check_eq("rst_idx",   sweep_idx, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single sweep 2..5, no dwell
        pulse_start(8'd2, 8'd5, 4'd1, 4'd0);
        check_eq("t1_busy_hi", busy, 1);
        wait_idle("t1");
        check_eq("t1_clr",   clr_cyc, 1);
        check_eq("t1_en",    en_cyc, 8);
        check_eq("t1_busy",  busy_cyc, 15);
        check_eq("t1_down",  down_cyc, 5);
        check_eq("t1_done",  done_cyc, 1);
        check_eq("t1_err",   err_cyc, 0);
        check_eq("t1_idx",   sweep_idx, 1);
        check_eq("t1_cnt",   cnt_value, 2);
        check_eq("t1_busy_lo", busy, 0);

        // Two sweeps 0..3 with dwell 3, seek is immediate
        pulse_start(8'd0, 8'd3, 4'd2, 4'd3);
        wait_idle("t2");
        check_eq("t2_busy",  busy_cyc, 35);
        check_eq("t2_en",    en_cyc, 12);
        check_eq("t2_down",  down_cyc, 16);
        check_eq("t2_hold3", hold3_cyc, 12);
        check_eq("t2_done",  done_cyc, 1);
        check_eq("t2_idx",   sweep_idx, 2);
        check_eq("t2_cnt",   cnt_value, 0);

        // Bad configurations
        pulse_start(8'd7, 8'd7, 4'd1, 4'd0);
        check_eq("t3a_err_now", err, 1);
        @(negedge clk); @(negedge clk);
        check_eq("t3a_err",  err_cyc, 1);
        check_eq("t3a_busy", busy_cyc, 0);
        check_eq("t3a_clr",  clr_cyc, 0);
        check_eq("t3a_idx",  sweep_idx, 2);
        pulse_start(8'd1, 8'd9, 4'd0, 4'd0);
        @(negedge clk); @(negedge clk);
        check_eq("t3b_err",  err_cyc, 1);
        check_eq("t3b_busy", busy_cyc, 0);
        check_eq("t3b_clr",  clr_cyc, 0);

        // Abort mid-UP at count 4
        pulse_start(8'd2, 8'd6, 4'd1, 4'd0);
        wait_cnt("t4", 8'd4, 1'b1);
        abort = 1'b1;
        #1;
        check_eq("t4_en_abort",  cnt_en, 0);
        check_eq("t4_clr_abort", cnt_clr, 0);
        @(negedge clk);
        abort = 1'b0;
        check_eq("t4_busy", busy, 0);
        @(negedge clk); @(negedge clk);
        check_eq("t4_cnt",  cnt_value, 4);
        check_eq("t4_done", done_cyc, 0);
        check_eq("t4_err",  err_cyc, 0);
        pulse_start(8'd2, 8'd5, 4'd1, 4'd0);
        wait_idle("t4r");
        check_eq("t4r_clr",  clr_cyc, 1);
        check_eq("t4r_en",   en_cyc, 8);
        check_eq("t4r_done", done_cyc, 1);
        check_eq("t4r_cnt",  cnt_value, 2);

        // Disturbed readback during UP
        pulse_start(8'd2, 8'd5, 4'd1, 4'd0);
        wait_cnt("t5", 8'd3, 1'b1);
        force_en = 1'b1; force_val = 8'd9;
        #1;
        check_eq("t5_en_rb", cnt_en, 0);
        @(negedge clk);
        check_eq("t5_busy",  busy, 0);
        check_eq("t5_err",   err, 1);
        force_en = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("t5_errcnt", err_cyc, 1);
        check_eq("t5_done",   done_cyc, 0);

        // Async reset mid-DOWN
        pulse_start(8'd2, 8'd5, 4'd3, 4'd0);
        wait_cnt("t6", 8'd4, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_eq("t6_clr",  cnt_clr, 0);
        check_eq("t6_en",   cnt_en, 0);
        check_eq("t6_dir",  cnt_dir, 1);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_done", done, 0);
        check_eq("t6_err",  err, 0);
        check_eq("t6_idx",  sweep_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
